dec_mul_ctrl: RTL and testbench

DEC_MUL_CTRL -- requirements
Module: dec_mul_ctrl

---
 rtl/dec_mul_ctrl.sv | 118 +++++++++++
 tb/tb_dec_mul_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_mul_ctrl.sv
// Sequencing controller for a BCD decimal multiplier: walks the multiplier digits,
// then steps the datapath through normalise and round, and holds the result status.
module dec_mul_ctrl #(
  parameter logic [8:0] BIAS = 9'd101,
  parameter int         NDIG = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] Ma,
  input  logic [27:0] Mb,
  input  logic [8:0]  Ea,
  input  logic [8:0]  Eb,
  output logic [3:0]  pp_digit,
  output logic        acc_clr,
  output logic        acc_en,
  output logic        norm_en,
  output logic        rnd_en,
  output logic [8:0]  Er_out,
  output logic        underflow_out,
  input  logic        rnd_overflow,
  input  logic        rnd_underflow,
  input  logic        rnd_inexact,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inx,
  output logic        res_zero
);

  typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

  localparam logic [2:0] LAST_DIG = 3'(NDIG - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [27:0] mb_q;
  logic [27:0] mb_sh;
  logic [9:0]  exp_sum;
  logic [9:0]  exp_diff;
  logic        accept;
  logic        zero_op;

  assign exp_sum  = {1'b0, Ea} + {1'b0, Eb};
  assign exp_diff = exp_sum - {1'b0, BIAS};
  assign zero_op  = (Ma == 28'd0) || (Mb == 28'd0);

  // Outputs decode directly from the state register so reset silences them at once
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign acc_clr   = accept && !zero_op;
  assign mb_sh     = mb_q >> {cnt, 2'b00};
  assign pp_digit  = (state == MULT) ? mb_sh[3:0] : 4'd0;
  assign acc_en    = (state == MULT) && (pp_digit != 4'd0);
  assign norm_en   = (state == NORM);
  assign rnd_en    = (state == ROUND);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      mb_q          <= 28'd0;
      Er_out        <= 9'd0;
      underflow_out <= 1'b0;
      flag_ovf      <= 1'b0;
      flag_unf      <= 1'b0;
      flag_inx      <= 1'b0;
      res_zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mb_q     <= Mb;
            cnt      <= 3'd0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
            if (zero_op) begin
              res_zero      <= 1'b1;
              Er_out        <= 9'd0;
              underflow_out <= 1'b0;
              state         <= DONE;
            end else begin
              res_zero      <= 1'b0;
              Er_out        <= exp_diff[8:0];
              underflow_out <= (exp_sum < {1'b0, BIAS});
              state         <= MULT;
            end
          end
        end
        MULT: begin
          // Fixed NDIG iterations; zero digits only suppress acc_en
          if (cnt == LAST_DIG) begin
            cnt   <= 3'd0;
            state <= NORM;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        NORM:  state <= ROUND;
        ROUND: begin
          flag_ovf <= rnd_overflow;
          flag_unf <= rnd_underflow;
          flag_inx <= rnd_inexact;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_mul_ctrl.sv
// Randomised and directed bench for dec_mul_ctrl against a cycle-indexed operation model.
module tb_dec_mul_ctrl;

  localparam int NDIG = 7;
  localparam int BIAS = 101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] Ma = '0;
  logic [27:0] Mb = '0;
  logic [8:0]  Ea = '0;
  logic [8:0]  Eb = '0;
  logic [3:0]  pp_digit;
  logic        acc_clr, acc_en, norm_en, rnd_en;
  logic [8:0]  Er_out;
  logic        underflow_out;
  logic        rnd_overflow = 1'b0;
  logic        rnd_underflow = 1'b0;
  logic        rnd_inexact = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        flag_ovf, flag_unf, flag_inx, res_zero;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dec_mul_ctrl #(.BIAS(9'd101), .NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ma(Ma), .Mb(Mb), .Ea(Ea), .Eb(Eb), .pp_digit(pp_digit),
    .acc_clr(acc_clr), .acc_en(acc_en), .norm_en(norm_en), .rnd_en(rnd_en),
    .Er_out(Er_out), .underflow_out(underflow_out),
    .rnd_overflow(rnd_overflow), .rnd_underflow(rnd_underflow), .rnd_inexact(rnd_inexact),
    .out_valid(out_valid), .out_ready(out_ready),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx), .res_zero(res_zero)
  );

  function automatic int digit_of(input logic [27:0] m, input int j);
    return int'((m >> (4 * j)) & 28'hF);
  endfunction

  function automatic logic [27:0] rand_bcd();
    logic [27:0] m = '0;
    for (int j = 0; j < NDIG; j++) begin
      int d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 9);
      m = m | (28'(d) << (4 * j));
    end
    return m;
  endfunction

  // One full operation: accept, per-cycle strobe checks, DONE status, back-pressure, handshake.
  task automatic drive_op(input logic [27:0] ma, input logic [27:0] mb,
                          input logic [8:0] ea, input logic [8:0] eb,
                          input logic ovf, input logic unf, input logic inx, input int bp);
    bit   zero = (ma == 0) || (mb == 0);
    int   s = int'(ea) + int'(eb);
    logic [8:0] exp_er = zero ? 9'd0 : 9'((s - BIAS) & 511);
    logic exp_un = zero ? 1'b0 : (s < BIAS);
    logic [2:0] exp_fl = zero ? 3'b000 : {ovf, unf, inx};
    int   last = zero ? 1 : NDIG + 3;
    int   n = 0;
    @(negedge clk);
    out_ready = 1'b0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    vecs++;
    if (!in_ready) begin
      errs++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      return;
    end
    Ma = ma; Mb = mb; Ea = ea; Eb = eb; in_valid = 1'b1;
    #1;
    vecs++;
    if (acc_clr !== !zero) begin
      errs++; $display("FAIL acc_clr_accept: got %b required %b", acc_clr, !zero);
    end
    for (int k = 1; k <= last; k++) begin
      int   dg = (!zero && k <= NDIG) ? digit_of(mb, k - 1) : 0;
      logic [6:0] got, want;
      @(negedge clk);
      in_valid = 1'($urandom);
      Mb = 28'($urandom);
      Ea = 9'($urandom); Eb = 9'($urandom);
      if (!zero && k == NDIG + 2) begin
        rnd_overflow = ovf; rnd_underflow = unf; rnd_inexact = inx;
      end else begin
        rnd_overflow = 1'($urandom); rnd_underflow = 1'($urandom); rnd_inexact = 1'($urandom);
      end
      #1;
      got  = {acc_clr, acc_en, norm_en, rnd_en, out_valid, in_ready, 1'b0};
      want = {1'b0, dg != 0, !zero && k == NDIG + 1, !zero && k == NDIG + 2, k == last, 1'b0, 1'b0};
      vecs++;
      if (got !== want) begin
        errs++; $display("FAIL strobes_k%0d: got %b required %b (clr,acc,norm,rnd,ov,rdy)", k, got, want);
      end
      vecs++;
      if (pp_digit !== 4'(dg)) begin
        errs++; $display("FAIL pp_digit_k%0d: got %0d required %0d", k, pp_digit, dg);
      end
    end
    for (int b = 0; b <= bp; b++) begin
      if (b > 0) begin
        @(negedge clk);
        in_valid = 1'($urandom);
        rnd_overflow = 1'($urandom); rnd_underflow = 1'($urandom); rnd_inexact = 1'($urandom);
        #1;
      end
      vecs++;
      if ({out_valid, Er_out, underflow_out, res_zero} !== {1'b1, exp_er, exp_un, zero}) begin
        errs++; $display("FAIL done_status_b%0d: ov=%b er=%h un=%b z=%b required ov=1 er=%h un=%b z=%b",
                         b, out_valid, Er_out, underflow_out, res_zero, exp_er, exp_un, zero);
      end
      vecs++;
      if ({flag_ovf, flag_unf, flag_inx} !== exp_fl) begin
        errs++; $display("FAIL done_flags_b%0d: got %b required %b", b, {flag_ovf, flag_unf, flag_inx}, exp_fl);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    vecs++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errs++; $display("FAIL handshake: ov,rdy=%b%b required 10", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    vecs++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errs++; $display("FAIL back_idle: ov,rdy=%b%b required 01", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; Ma = 28'h5; Mb = 28'h3;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if ({out_valid, acc_clr, acc_en, norm_en, rnd_en, pp_digit} !== 9'd0) begin
      errs++; $display("FAIL reset_ctrl: got %b required 0", {out_valid, acc_clr, acc_en, norm_en, rnd_en, pp_digit});
    end
    vecs++;
    if ({Er_out, underflow_out, flag_ovf, flag_unf, flag_inx, res_zero} !== 14'd0) begin
      errs++; $display("FAIL reset_status: got %h required 0", {Er_out, underflow_out, flag_ovf, flag_unf, flag_inx, res_zero});
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_normal();
    drive_op(28'h0000005, 28'h0000003, 9'd101, 9'd101, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_zero_bypass();
    drive_op(28'h1234567, 28'h0, 9'd200, 9'd150, 1'b1, 1'b1, 1'b1, 2);
    drive_op(28'h0, 28'h9999999, 9'd3, 9'd7, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_underflow();
    drive_op(28'h0000012, 28'h0000034, 9'd40, 9'd50, 1'b0, 1'b1, 1'b0, 1);
  endtask

  task automatic test_flags();
    drive_op(28'h9876543, 28'h1020304, 9'd120, 9'd90, 1'b1, 1'b0, 1'b1, 5);
  endtask

  task automatic test_reset_mid_mult();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    Ma = 28'h7654321; Mb = 28'h8765432; Ea = 9'd200; Eb = 9'd200; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    vecs++;
    if ({acc_en, pp_digit} !== {1'b1, 4'h5}) begin
      errs++; $display("FAIL mid_mult_digit3: acc,pp=%b,%h required 1,5", acc_en, pp_digit);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid, acc_clr, acc_en, norm_en, rnd_en, pp_digit} !== 9'd0) begin
      errs++; $display("FAIL mid_reset_ctrl: got %b required 0", {out_valid, acc_clr, acc_en, norm_en, rnd_en, pp_digit});
    end
    vecs++;
    if ({Er_out, underflow_out, flag_ovf, flag_unf, flag_inx, res_zero} !== 14'd0) begin
      errs++; $display("FAIL mid_reset_status: got %h required 0", {Er_out, underflow_out, flag_ovf, flag_unf, flag_inx, res_zero});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_op(28'h0000021, 28'h0304050, 9'd60, 9'd70, 1'b0, 1'b1, 1'b1, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [27:0] ma = rand_bcd();
      logic [27:0] mb = rand_bcd();
      if ($urandom_range(0, 7) == 0) mb = 28'd0;
      drive_op(ma, mb, 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    int a1 = -1, a2 = -1, v1 = -1, v2 = -1;
    @(negedge clk);
    Ma = 28'h0000101; Mb = 28'h0203040; Ea = 9'd110; Eb = 9'd100;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && v2 < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (a2 >= 0) in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        if (a1 < 0) a1 = c; else if (a2 < 0) a2 = c;
      end
      if (out_valid) begin
        if (v1 < 0) v1 = c; else if (a2 >= 0 && v2 < 0) v2 = c;
      end
    end
    out_ready = 1'b0;
    vecs++;
    if (v1 - a1 !== NDIG + 3) begin
      errs++; $display("FAIL b2b_latency1: got %0d required %0d", v1 - a1, NDIG + 3);
    end
    vecs++;
    if (a2 - v1 !== 1) begin
      errs++; $display("FAIL b2b_reaccept: second accept %0d cycles after out_valid cycle, required 1 (2 edges)", a2 - v1);
    end
    vecs++;
    if (v2 - a2 !== NDIG + 3) begin
      errs++; $display("FAIL b2b_latency2: got %0d required %0d", v2 - a2, NDIG + 3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL b2b_drain: in_ready=%b required 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_bypass();
    test_underflow();
    test_flags();
    test_reset_mid_mult();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
